trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush is held after a trap or mret (1..15).
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset (synchronous, active-high).
REQ-003 SHALL have ports: software_interrupt, timer_interrupt, external_interrupt  in  1 each  level interrupt requests; debug_interrupt  in  1  ignored.
REQ-004 SHALL have ports: wb_valid  in  1  instruction retiring in WB; wb_pc  in  32  its PC; wb_exception  in  1  it faulted; wb_exc_code  in  4  mcause code; wb_tval  in  32  fault value; wb_mret  in  1  it is mret.
REQ-005 SHALL have ports: o_mstatus_mie, o_mstatus_mpie  in  1  current CSR state; o_mtvec_base  in  30; o_mtvec_mode  in  2; o_mepc_value  in  32.
REQ-006 SHALL have ports: trap  out  1  CSR trap-entry strobe; i_mcause_exception_code  out  31; i_mcause_interrupt  out  1; i_mepc_value  out  32; i_mstatus_mie, i_mstatus_mpie  out  1; i_mstatus_mpp  out  2; i_mtval_value  out  32.
REQ-007 SHALL have ports: mret_restore  out  1  CSR mstatus-restore strobe; wb_kill  out  1  suppress WB register write; flush  out  1  pipeline flush; redirect_valid  out  1; redirect_pc  out  32.

Function
REQ-008 SHALL implement FSM IDLE, ENTER, FLUSH; all outputs except wb_kill SHALL be registered.
REQ-009 SHALL register the three interrupt inputs once (pending = one-cycle-delayed level).
REQ-010 In IDLE, a cycle with wb_valid & wb_exception SHALL be an exception event: mcause_interrupt=0, code=wb_exc_code, mepc=wb_pc, mtval=wb_tval.
REQ-011 In IDLE, wb_valid & ~wb_exception & wb_mret SHALL be an mret event: next cycle mret_restore=1 for one cycle, redirect_pc=o_mepc_value.
REQ-012 In IDLE, wb_valid & ~wb_exception & ~wb_mret & o_mstatus_mie & any pending SHALL be an interrupt event: mcause_interrupt=1, mepc=wb_pc+4, mtval=0.
REQ-013 Priority SHALL be exception > mret > interrupt; among interrupts external (11) > software (3) > timer (7).
REQ-014 An event SHALL move IDLE->ENTER; ENTER SHALL last one cycle with trap=1 (trap events) or mret_restore=1 (mret), redirect_valid=1, flush=1.
REQ-015 On trap entry: i_mstatus_mpie=o_mstatus_mie, i_mstatus_mie=0, i_mstatus_mpp=2'b11; redirect_pc={o_mtvec_base,2'b00} (see REQ-023).
REQ-016 ENTER SHALL go to FLUSH; FLUSH SHALL hold flush=1 for FLUSH_CYCLES cycles via a down-counter, then return to IDLE.
REQ-017 In ENTER/FLUSH, WB inputs and pending interrupts SHALL be ignored (not queued); level interrupts still asserted are taken after return to IDLE.
REQ-018 wb_kill SHALL be combinational = wb_valid & wb_exception & (state==IDLE).
REQ-019 i_mepc_value bit 1:0 SHALL be forced to 0; wb_pc+4 SHALL wrap modulo 2^32.
REQ-020 Interrupts with o_mstatus_mie=0 SHALL not be taken; exceptions SHALL be taken regardless.

Reset
REQ-021 rst SHALL force state IDLE, counter 0, pending 0, and all outputs 0 (i_mstatus_mpp=0), including mid-ENTER/FLUSH.
REQ-022 The cycle after rst deasserts SHALL accept events normally.

Configuration
REQ-023 With TRAP_CTRL_VECTORED_EN defined and o_mtvec_mode==1, interrupt redirect_pc SHALL be {o_mtvec_base,2'b00}+4*code; exceptions use the base; without the macro mode SHALL be ignored and all traps use the base.

Structure
REQ-024 State enum, mcause code constants (2,3,4,6,11 exception; 3,7,11 interrupt) and MPP_MACHINE SHALL reside in the shared core package/core.svh.
REQ-025 No sub-module; instantiated beside csr in WB, its i_* outputs wiring directly to csr inputs.

Verification
REQ-026 wb_valid, wb_exception, code=2, pc=0x100, tval=0xDEAD, mie=1 -> wb_kill same cycle; next cycle trap=1, cause=2, int=0, mepc=0x100, mpie=1, mie=0, mpp=3; flush 3 cycles total.
REQ-027 timer_interrupt=1, mie=1, retire pc=0x200, mtvec_base=0x10 -> trap, cause=7, int=1, mepc=0x204, redirect_pc=0x40 (0x5C if VECTORED_EN and mode=1).
REQ-028 external+software+timer all high -> cause=11; with o_mstatus_mie=0 -> no trap.
REQ-029 exception and timer pending same cycle -> exception taken; timer taken after FLUSH completes.
REQ-030 wb_mret, o_mepc_value=0x300 -> mret_restore one cycle, redirect_pc=0x300, trap=0.
REQ-031 rst asserted during FLUSH -> next cycle all outputs 0, state IDLE; wb_pc=0xFFFFFFFC interrupt -> mepc=0x0.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states, mcause codes, MPP encoding.
package trap_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_FLUSH = 2'd2
    } trap_state_e;

    typedef enum logic [3:0] {
        EXC_ILLEGAL_INSN     = 4'd2,
        EXC_BREAKPOINT       = 4'd3,
        EXC_LOAD_MISALIGNED  = 4'd4,
        EXC_STORE_MISALIGNED = 4'd6,
        EXC_ECALL_M          = 4'd11
    } exc_code_e;

    typedef enum logic [3:0] {
        IRQ_M_SOFT  = 4'd3,
        IRQ_M_TIMER = 4'd7,
        IRQ_M_EXT   = 4'd11
    } irq_code_e;

    localparam logic [1:0] MPP_MACHINE = 2'b11;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer sitting beside the CSR file in WB.
// Optional vectored interrupt dispatch: define TRAP_CTRL_VECTORED_EN.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            software_interrupt,
    input  logic            timer_interrupt,
    input  logic            external_interrupt,
    input  logic            debug_interrupt,
    input  logic            wb_valid,
    input  logic [31:0]     wb_pc,
    input  logic            wb_exception,
    input  logic [3:0]      wb_exc_code,
    input  logic [31:0]     wb_tval,
    input  logic            wb_mret,
    input  logic            o_mstatus_mie,
    input  logic            o_mstatus_mpie,
    input  logic [29:0]     o_mtvec_base,
    input  logic [1:0]      o_mtvec_mode,
    input  logic [31:0]     o_mepc_value,
    output logic            trap,
    output logic [30:0]     i_mcause_exception_code,
    output logic            i_mcause_interrupt,
    output logic [31:0]     i_mepc_value,
    output logic            i_mstatus_mie,
    output logic            i_mstatus_mpie,
    output logic [1:0]      i_mstatus_mpp,
    output logic [31:0]     i_mtval_value,
    output logic            mret_restore,
    output logic            wb_kill,
    output logic            flush,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc
);

    trap_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_pend_sw, r_pend_tm, r_pend_ext;

    logic             r_trap, w_trap_nxt;
    logic [30:0]      r_cause, w_cause_nxt;
    logic             r_intr, w_intr_nxt;
    logic [31:0]      r_mepc, w_mepc_nxt;
    logic             r_mie, w_mie_nxt;
    logic             r_mpie, w_mpie_nxt;
    logic [1:0]       r_mpp, w_mpp_nxt;
    logic [31:0]      r_mtval, w_mtval_nxt;
    logic             r_mret, w_mret_nxt;
    logic             r_flush, w_flush_nxt;
    logic             r_rv, w_rv_nxt;
    logic [31:0]      r_rpc, w_rpc_nxt;

    logic             w_exc_evt, w_mret_evt, w_int_evt;
    logic [3:0]       w_irq_code;
    logic [31:0]      w_base_pc, w_int_pc;
    logic             w_unused_ok;

    assign w_exc_evt  = wb_valid & wb_exception;
    assign w_mret_evt = wb_valid & ~wb_exception & wb_mret;
    assign w_int_evt  = wb_valid & ~wb_exception & ~wb_mret & o_mstatus_mie
                      & (r_pend_sw | r_pend_tm | r_pend_ext);

    // External outranks software, which outranks timer.
    assign w_irq_code = r_pend_ext ? IRQ_M_EXT  :
                        r_pend_sw  ? IRQ_M_SOFT : IRQ_M_TIMER;

    assign w_base_pc = {o_mtvec_base, 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
    assign w_int_pc  = (o_mtvec_mode == 2'd1) ? w_base_pc + {26'd0, w_irq_code, 2'b00}
                                               : w_base_pc;
`else
    assign w_int_pc  = w_base_pc;
`endif

    assign w_unused_ok = ^{debug_interrupt, o_mstatus_mpie, o_mtvec_mode};

    // Only a faulting instruction seen while idle loses its register write.
    assign wb_kill = wb_valid & wb_exception & (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_trap_nxt  = 1'b0;
        w_mret_nxt  = 1'b0;
        w_rv_nxt    = 1'b0;
        w_flush_nxt = 1'b0;
        w_cause_nxt = r_cause;
        w_intr_nxt  = r_intr;
        w_mepc_nxt  = r_mepc;
        w_mie_nxt   = r_mie;
        w_mpie_nxt  = r_mpie;
        w_mpp_nxt   = r_mpp;
        w_mtval_nxt = r_mtval;
        w_rpc_nxt   = r_rpc;
        case (r_state)
            ST_IDLE: begin
                if (w_exc_evt || w_mret_evt || w_int_evt) begin
                    w_state_nxt = ST_ENTER;
                    w_rv_nxt    = 1'b1;
                    w_flush_nxt = 1'b1;
                end
                if (w_exc_evt) begin
                    w_trap_nxt  = 1'b1;
                    w_cause_nxt = 31'(wb_exc_code);
                    w_intr_nxt  = 1'b0;
                    w_mepc_nxt  = word_align(wb_pc);
                    w_mtval_nxt = wb_tval;
                    w_mie_nxt   = 1'b0;
                    w_mpie_nxt  = o_mstatus_mie;
                    w_mpp_nxt   = MPP_MACHINE;
                    w_rpc_nxt   = w_base_pc;
                end else if (w_mret_evt) begin
                    w_mret_nxt  = 1'b1;
                    w_rpc_nxt   = o_mepc_value;
                end else if (w_int_evt) begin
                    w_trap_nxt  = 1'b1;
                    w_cause_nxt = 31'(w_irq_code);
                    w_intr_nxt  = 1'b1;
                    w_mepc_nxt  = word_align(wb_pc + 32'd4);
                    w_mtval_nxt = 32'd0;
                    w_mie_nxt   = 1'b0;
                    w_mpie_nxt  = o_mstatus_mie;
                    w_mpp_nxt   = MPP_MACHINE;
                    w_rpc_nxt   = w_int_pc;
                end
            end
            ST_ENTER: begin
                w_state_nxt = ST_FLUSH;
                w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
                w_flush_nxt = 1'b1;
            end
            ST_FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_flush_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pend_sw  <= 1'b0;
            r_pend_tm  <= 1'b0;
            r_pend_ext <= 1'b0;
            r_trap     <= 1'b0;
            r_cause    <= '0;
            r_intr     <= 1'b0;
            r_mepc     <= '0;
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mpp      <= '0;
            r_mtval    <= '0;
            r_mret     <= 1'b0;
            r_flush    <= 1'b0;
            r_rv       <= 1'b0;
            r_rpc      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_sw  <= software_interrupt;
            r_pend_tm  <= timer_interrupt;
            r_pend_ext <= external_interrupt;
            r_trap     <= w_trap_nxt;
            r_cause    <= w_cause_nxt;
            r_intr     <= w_intr_nxt;
            r_mepc     <= w_mepc_nxt;
            r_mie      <= w_mie_nxt;
            r_mpie     <= w_mpie_nxt;
            r_mpp      <= w_mpp_nxt;
            r_mtval    <= w_mtval_nxt;
            r_mret     <= w_mret_nxt;
            r_flush    <= w_flush_nxt;
            r_rv       <= w_rv_nxt;
            r_rpc      <= w_rpc_nxt;
        end
    end

    assign trap                    = r_trap;
    assign i_mcause_exception_code = r_cause;
    assign i_mcause_interrupt      = r_intr;
    assign i_mepc_value            = r_mepc;
    assign i_mstatus_mie           = r_mie;
    assign i_mstatus_mpie          = r_mpie;
    assign i_mstatus_mpp           = r_mpp;
    assign i_mtval_value           = r_mtval;
    assign mret_restore            = r_mret;
    assign flush                   = r_flush;
    assign redirect_valid          = r_rv;
    assign redirect_pc             = r_rpc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboarded bench for trap_ctrl: trap entry, interrupt priority, mret, reset and wrap cases.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int unsigned FC = 2;
`ifdef TRAP_CTRL_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        software_interrupt, timer_interrupt, external_interrupt, debug_interrupt;
    logic        wb_valid, wb_exception, wb_mret;
    logic [31:0] wb_pc, wb_tval;
    logic [3:0]  wb_exc_code;
    logic        o_mstatus_mie, o_mstatus_mpie;
    logic [29:0] o_mtvec_base;
    logic [1:0]  o_mtvec_mode;
    logic [31:0] o_mepc_value;
    logic        trap, i_mcause_interrupt, i_mstatus_mie, i_mstatus_mpie;
    logic [30:0] i_mcause_exception_code;
    logic [31:0] i_mepc_value, i_mtval_value, redirect_pc;
    logic [1:0]  i_mstatus_mpp;
    logic        mret_restore, wb_kill, flush, redirect_valid;

    typedef struct packed {
        logic        trap;
        logic        mret;
        logic [30:0] cause;
        logic        intr;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic        mie;
        logic        mpie;
        logic [1:0]  mpp;
        logic [31:0] rpc;
        logic        rv;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .software_interrupt(software_interrupt), .timer_interrupt(timer_interrupt),
        .external_interrupt(external_interrupt), .debug_interrupt(debug_interrupt),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exception(wb_exception),
        .wb_exc_code(wb_exc_code), .wb_tval(wb_tval), .wb_mret(wb_mret),
        .o_mstatus_mie(o_mstatus_mie), .o_mstatus_mpie(o_mstatus_mpie),
        .o_mtvec_base(o_mtvec_base), .o_mtvec_mode(o_mtvec_mode), .o_mepc_value(o_mepc_value),
        .trap(trap), .i_mcause_exception_code(i_mcause_exception_code),
        .i_mcause_interrupt(i_mcause_interrupt), .i_mepc_value(i_mepc_value),
        .i_mstatus_mie(i_mstatus_mie), .i_mstatus_mpie(i_mstatus_mpie),
        .i_mstatus_mpp(i_mstatus_mpp), .i_mtval_value(i_mtval_value),
        .mret_restore(mret_restore), .wb_kill(wb_kill), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    function automatic exp_t observed();
        return '{trap: trap, mret: mret_restore, cause: i_mcause_exception_code,
                 intr: i_mcause_interrupt, mepc: i_mepc_value, mtval: i_mtval_value,
                 mie: i_mstatus_mie, mpie: i_mstatus_mpie, mpp: i_mstatus_mpp,
                 rpc: redirect_pc, rv: redirect_valid};
    endfunction

    function automatic exp_t trap_exp(input logic [3:0] code, input logic intr,
                                      input logic [31:0] mepc, input logic [31:0] mtval,
                                      input logic mpie, input logic [31:0] rpc);
        return '{trap: 1'b1, mret: 1'b0, cause: 31'(code), intr: intr, mepc: mepc,
                 mtval: mtval, mie: 1'b0, mpie: mpie, mpp: 2'b11, rpc: rpc, rv: 1'b1};
    endfunction

    function automatic logic [31:0] int_rpc(input logic [3:0] code);
        logic [31:0] base;
        base = {o_mtvec_base, 2'b00};
        if (VEC && o_mtvec_mode == 2'd1) return base + {26'd0, code, 2'b00};
        return base;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = 1'b0; wb_exception = 1'b0; wb_mret = 1'b0;
    endtask

    task automatic await_strobe(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (trap || mret_restore) begin
                got = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic await_flush_end(output int n);
        n = 0;
        while (flush && n < 20) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if ({trap, i_mcause_exception_code, i_mcause_interrupt, i_mepc_value, i_mstatus_mie,
             i_mstatus_mpie, i_mstatus_mpp, i_mtval_value, mret_restore, wb_kill, flush,
             redirect_valid, redirect_pc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got trap=%b cause=%h mepc=%h mpp=%b flush=%b rpc=%h exp all 0",
                     trap, i_mcause_exception_code, i_mepc_value, i_mstatus_mpp, flush, redirect_pc);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_exception();
        bit got; int n; exp_t e, o;
        wb_valid = 1'b1; wb_exception = 1'b1; wb_exc_code = 4'd2;
        wb_pc = 32'h100; wb_tval = 32'hDEAD;
        #1;
        checks++;
        if (wb_kill !== 1'b1) begin
            errors++; $display("FAIL exc_wb_kill: got %b exp 1", wb_kill);
        end
        sb.push_back(trap_exp(4'd2, 1'b0, 32'h100, 32'hDEAD, 1'b1, 32'h40));
        step(); clear_wb();
        await_strobe(got); e = sb.pop_front(); o = observed();
        checks++;
        if (!got || o !== e) begin
            errors++; $display("FAIL exc_entry: got %h exp %h (strobe=%b)", o, e, got);
        end
        wb_valid = 1'b1; wb_exception = 1'b1; wb_pc = 32'h104;
        #1;
        checks++;
        if (wb_kill !== 1'b0) begin
            errors++; $display("FAIL exc_kill_in_enter: got %b exp 0", wb_kill);
        end
        clear_wb();
        await_flush_end(n);
        checks++;
        if (n !== int'(FC + 1)) begin
            errors++; $display("FAIL exc_flush_len: got %0d exp %0d", n, FC + 1);
        end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (trap || redirect_valid) n++;
            step();
        end
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL exc_not_queued: got %0d strobes exp 0", n);
        end
    endtask

    task automatic test_interrupt(input string name, input logic sw, input logic tm,
                                  input logic ext, input logic [3:0] code,
                                  input logic [31:0] pc, input logic [31:0] mepc);
        bit got; int n; exp_t e, o;
        software_interrupt = sw; timer_interrupt = tm; external_interrupt = ext;
        step();
        wb_valid = 1'b1; wb_pc = pc;
        sb.push_back(trap_exp(code, 1'b1, mepc, 32'd0, 1'b1, int_rpc(code)));
        step(); clear_wb();
        software_interrupt = 1'b0; timer_interrupt = 1'b0; external_interrupt = 1'b0;
        await_strobe(got); e = sb.pop_front(); o = observed();
        checks++;
        if (!got || o !== e) begin
            errors++; $display("FAIL %s: got %h exp %h (strobe=%b)", name, o, e, got);
        end
        await_flush_end(n);
        step(); step();
    endtask

    task automatic test_mie_masked();
        int n;
        o_mstatus_mie = 1'b0;
        software_interrupt = 1'b1; timer_interrupt = 1'b1; external_interrupt = 1'b1;
        step();
        wb_valid = 1'b1; wb_pc = 32'h210;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (trap || redirect_valid || flush) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL mie_masked: got %0d strobes exp 0", n);
        end
        clear_wb();
        software_interrupt = 1'b0; timer_interrupt = 1'b0; external_interrupt = 1'b0;
        o_mstatus_mie = 1'b1;
        step(); step();
    endtask

    task automatic test_back_to_back();
        bit got; int n; exp_t e, o;
        timer_interrupt = 1'b1;
        step();
        wb_valid = 1'b1; wb_exception = 1'b1; wb_exc_code = 4'd4;
        wb_pc = 32'h400; wb_tval = 32'h403;
        sb.push_back(trap_exp(4'd4, 1'b0, 32'h400, 32'h403, 1'b1, 32'h40));
        sb.push_back(trap_exp(4'd7, 1'b1, 32'h40C, 32'd0, 1'b1, int_rpc(4'd7)));
        step();
        wb_exception = 1'b0; wb_pc = 32'h408;
        await_strobe(got); e = sb.pop_front(); o = observed();
        checks++;
        if (!got || o !== e) begin
            errors++; $display("FAIL b2b_exception_first: got %h exp %h (strobe=%b)", o, e, got);
        end
        step();
        await_flush_end(n);
        checks++;
        if (n !== int'(FC)) begin
            errors++; $display("FAIL b2b_flush_before_irq: got %0d exp %0d", n, FC);
        end
        await_strobe(got); e = sb.pop_front(); o = observed();
        checks++;
        if (!got || o !== e) begin
            errors++; $display("FAIL b2b_timer_after: got %h exp %h (strobe=%b)", o, e, got);
        end
        clear_wb(); timer_interrupt = 1'b0;
        await_flush_end(n);
        step(); step();
    endtask

    task automatic test_mret();
        bit got; int n; exp_t e, o;
        o_mepc_value = 32'h300;
        wb_valid = 1'b1; wb_mret = 1'b1; wb_pc = 32'h500;
        e = '0; e.mret = 1'b1; e.rpc = 32'h300; e.rv = 1'b1;
        sb.push_back(e);
        step(); clear_wb();
        await_strobe(got); e = sb.pop_front(); o = observed();
        checks++;
        if (!got || {o.trap, o.mret, o.rpc, o.rv} !== {e.trap, e.mret, e.rpc, e.rv}) begin
            errors++; $display("FAIL mret_entry: got trap=%b restore=%b rpc=%h rv=%b exp 0 1 %h 1",
                               o.trap, o.mret, o.rpc, o.rv, e.rpc);
        end
        step();
        checks++;
        if ({mret_restore, trap, redirect_valid} !== 3'b000) begin
            errors++; $display("FAIL mret_one_cycle: got restore=%b trap=%b rv=%b exp 000",
                               mret_restore, trap, redirect_valid);
        end
        await_flush_end(n);
        step();
    endtask

    task automatic test_reset_flush();
        bit got; int n; exp_t e, o;
        wb_valid = 1'b1; wb_exception = 1'b1; wb_exc_code = 4'd3;
        wb_pc = 32'h600; wb_tval = 32'h1;
        sb.push_back(trap_exp(4'd3, 1'b0, 32'h600, 32'h1, 1'b1, 32'h40));
        step(); clear_wb();
        await_strobe(got); e = sb.pop_front(); o = observed();
        checks++;
        if (!got || o !== e) begin
            errors++; $display("FAIL rstflush_entry: got %h exp %h (strobe=%b)", o, e, got);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({observed(), flush, wb_kill} !== '0) begin
            errors++; $display("FAIL rstflush_outputs: got %h flush=%b exp all 0", observed(), flush);
        end
        rst = 1'b0;
        o_mstatus_mie = 1'b0;
        wb_valid = 1'b1; wb_exception = 1'b1; wb_exc_code = 4'd6;
        wb_pc = 32'h507; wb_tval = 32'h7;
        sb.push_back(trap_exp(4'd6, 1'b0, 32'h504, 32'h7, 1'b0, 32'h40));
        step(); clear_wb();
        checks++;
        if (trap !== 1'b1) begin
            errors++; $display("FAIL rstflush_accept_next: got trap=%b exp 1", trap);
        end
        await_strobe(got); e = sb.pop_front(); o = observed();
        checks++;
        if (!got || o !== e) begin
            errors++; $display("FAIL rstflush_exc_mie0: got %h exp %h (strobe=%b)", o, e, got);
        end
        o_mstatus_mie = 1'b1;
        await_flush_end(n);
        step();
    endtask

    initial begin
        rst = 1'b1;
        software_interrupt = 1'b0; timer_interrupt = 1'b0; external_interrupt = 1'b0;
        debug_interrupt = 1'b0;
        wb_valid = 1'b0; wb_exception = 1'b0; wb_mret = 1'b0;
        wb_pc = '0; wb_tval = '0; wb_exc_code = '0;
        o_mstatus_mie = 1'b1; o_mstatus_mpie = 1'b0;
        o_mtvec_base = 30'h10; o_mtvec_mode = 2'd1; o_mepc_value = '0;
        step(); step();

        test_reset();
        test_exception();
        test_interrupt("irq_timer", 1'b0, 1'b1, 1'b0, 4'd7, 32'h200, 32'h204);
        test_interrupt("irq_all_ext", 1'b1, 1'b1, 1'b1, 4'd11, 32'h208, 32'h20C);
        test_interrupt("irq_sw_over_timer", 1'b1, 1'b1, 1'b0, 4'd3, 32'h220, 32'h224);
        test_mie_masked();
        test_back_to_back();
        test_mret();
        test_reset_flush();
        test_interrupt("irq_pc_wrap", 1'b0, 1'b1, 1'b0, 4'd7, 32'hFFFF_FFFC, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
